// File: rtl/target_timer_ctrl.sv
// Game register controller: game timer, two target countdown timers, button synchronizer and hit detection.
// Optional macro TARGET_SPEEDUP_EN shortens the target reload value on every hit.
module target_timer_ctrl #(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned TARGET_MS       = 1500,
  parameter int unsigned GAME_MS         = 60000,
  parameter int unsigned SPEEDUP_STEP_MS = 100,
  parameter int unsigned TARGET_MIN_MS   = 500
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        game_start,
  input  logic [5:0]  button_in,
  input  logic [31:0] t1active_read,
  input  logic [31:0] t2active_read,
  output logic [31:0] bp_write,
  output logic [31:0] t1hit_write,
  output logic [31:0] t2hit_write,
  output logic [31:0] timer1_write,
  output logic [31:0] timer2_write,
  output logic [31:0] gametimer_write,
  output logic        game_over
);

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [5:0]    sync1_q, sync2_q, sync3_q;
  logic [31:0]   game_q, game_d;
  logic          game_over_q, game_over_d;
  logic [31:0]   timer_q [2];
  logic [31:0]   timer_d [2];
  logic          hit_q [2];
  logic          hit_d [2];
  logic [3:0]    prev_q [2];
  logic [3:0]    prev_d [2];

  logic [3:0]    idx [2];
  logic          idx_valid [2];
  logic          new_hit [2];
  logic [5:0]    rise;
  logic          run, tick, restart;
  logic [31:0]   reload;
  logic [55:0]   unused_idx_bits;

  assign idx[0]          = t1active_read[3:0];
  assign idx[1]          = t2active_read[3:0];
  assign unused_idx_bits = {t1active_read[31:4], t2active_read[31:4]};
  assign rise            = sync2_q & ~sync3_q;
  assign run             = (state_q == S_RUN);
  assign tick            = run && (tick_cnt_q == TICK_LAST);
  assign restart         = game_start && (state_q != S_IDLE);

  function automatic logic button_rise(input logic [5:0] r, input logic [3:0] i);
    button_rise = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (i == 4'(k + 4)) button_rise = r[k];
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    game_d     = game_q;
    unique case (state_q)
      S_IDLE: begin
        game_d = GAME_MS;
        if (game_start) begin
          state_d    = S_RUN;
          tick_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (game_start) begin
          game_d     = GAME_MS;
          tick_cnt_d = '0;
        end else if (tick) begin
          tick_cnt_d = '0;
          // The final tick lands in DONE on the same edge that shows zero.
          if (game_q <= 32'd1) begin
            game_d  = '0;
            state_d = S_DONE;
          end else begin
            game_d = game_q - 32'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (game_start) begin
          state_d    = S_RUN;
          game_d     = GAME_MS;
          tick_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    game_over_d = (state_d == S_DONE);
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      idx_valid[c] = (idx[c] >= 4'd4) && (idx[c] <= 4'd9);
      timer_d[c]   = timer_q[c];
      hit_d[c]     = hit_q[c];
      prev_d[c]    = prev_q[c];
      new_hit[c]   = 1'b0;
      // Restart leaves prev idx alone so a simultaneous index change still loads next cycle.
      if (restart) begin
        timer_d[c] = '0;
        hit_d[c]   = 1'b0;
      end else if (idx[c] != prev_q[c]) begin
        prev_d[c]  = idx[c];
        hit_d[c]   = 1'b0;
        timer_d[c] = idx_valid[c] ? reload : '0;
      end else if (run) begin
        if (idx_valid[c] && (timer_q[c] != '0) && !hit_q[c] && button_rise(rise, idx[c])) begin
          hit_d[c]   = 1'b1;
          new_hit[c] = 1'b1;
        end else if (tick && !hit_q[c] && (timer_q[c] != '0)) begin
          timer_d[c] = timer_q[c] - 32'd1;
        end
      end
    end
  end

`ifdef TARGET_SPEEDUP_EN
  localparam logic [31:0] STEP32 = 32'(SPEEDUP_STEP_MS);
  localparam logic [31:0] MIN32  = 32'(TARGET_MIN_MS);

  logic [31:0] reload_q, reload_d, reload_dec;

  always_comb begin
    reload_dec = (new_hit[0] ? STEP32 : 32'd0) + (new_hit[1] ? STEP32 : 32'd0);
    reload_d   = reload_q;
    if (game_start) begin
      reload_d = TARGET_MS;
    end else if (reload_dec != 32'd0) begin
      reload_d = (reload_q >= MIN32 + reload_dec) ? (reload_q - reload_dec) : MIN32;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) reload_q <= TARGET_MS;
    else               reload_q <= reload_d;
  end

  assign reload = reload_q;
`else
  logic [63:0] unused_speedup;
  assign unused_speedup = {SPEEDUP_STEP_MS, TARGET_MIN_MS};
  assign reload         = TARGET_MS;
`endif

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      game_q      <= GAME_MS;
      game_over_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        timer_q[c] <= '0;
        hit_q[c]   <= 1'b0;
        prev_q[c]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sync1_q     <= button_in;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      game_q      <= game_d;
      game_over_q <= game_over_d;
      for (int c = 0; c < 2; c++) begin
        timer_q[c] <= timer_d[c];
        hit_q[c]   <= hit_d[c];
        prev_q[c]  <= prev_d[c];
      end
    end
  end

  assign bp_write        = {26'b0, sync2_q};
  assign t1hit_write     = {31'b0, hit_q[0]};
  assign t2hit_write     = {31'b0, hit_q[1]};
  assign timer1_write    = timer_q[0];
  assign timer2_write    = timer_q[1];
  assign gametimer_write = game_q;
  assign game_over       = game_over_q;

endmodule

// File: tb/tb_target_timer_ctrl.sv
// Scoreboard bench for target_timer_ctrl: a reference model pushes expected outputs every clock,
// a negedge monitor pops and compares them; directed scenarios add a few absolute checks.
`timescale 1ns/1ps
module tb_target_timer_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int TARGET_MS = 10;
  localparam int GAME_MS   = 50;
  localparam int STEP_MS   = 3;
  localparam int MIN_MS    = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        game_start = 1'b0;
  logic [5:0]  button_in = '0;
  logic [31:0] t1active_read = '0;
  logic [31:0] t2active_read = '0;
  logic [31:0] bp_write, t1hit_write, t2hit_write, timer1_write, timer2_write, gametimer_write;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  target_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .TARGET_MS(TARGET_MS), .GAME_MS(GAME_MS),
    .SPEEDUP_STEP_MS(STEP_MS), .TARGET_MIN_MS(MIN_MS)
  ) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .game_start(game_start), .button_in(button_in),
    .t1active_read(t1active_read), .t2active_read(t2active_read),
    .bp_write(bp_write), .t1hit_write(t1hit_write), .t2hit_write(t2hit_write),
    .timer1_write(timer1_write), .timer2_write(timer2_write),
    .gametimer_write(gametimer_write), .game_over(game_over)
  );

  typedef struct {
    logic [31:0] bp, h1, h2, t1, t2, gt, go;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: game progress is counted in elapsed edges since the last start.
  bit         m_live, m_running, m_over;
  int         m_edges, m_game, m_reload;
  int         m_timer [2];
  bit         m_hit [2];
  int         m_prev [2];
  logic [5:0] m_hist [3];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_bp"}, bp_write, 0);
    checkOutput({tag, "_hit1"}, t1hit_write, 0);
    checkOutput({tag, "_hit2"}, t2hit_write, 0);
    checkOutput({tag, "_timer1"}, timer1_write, 0);
    checkOutput({tag, "_timer2"}, timer2_write, 0);
    checkOutput({tag, "_gametimer"}, gametimer_write, GAME_MS);
    checkOutput({tag, "_game_over"}, {31'b0, game_over}, 0);
  endtask

  task automatic modelReset();
    m_live = 0; m_running = 0; m_over = 0;
    m_edges = 0; m_game = GAME_MS; m_reload = TARGET_MS;
    for (int c = 0; c < 2; c++) begin
      m_timer[c] = 0; m_hit[c] = 0; m_prev[c] = 0;
    end
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
    sb.delete();
  endtask

  task automatic modelStep();
    logic [5:0] rise;
    bit         gs, restart, tick, valid;
    int         nh, idx;
    exp_t       e;
    gs      = game_start;
    // m_hist[0] holds the button level sampled one edge ago; the synchronized edge lags two more.
    rise    = m_hist[1] & ~m_hist[2];
    restart = gs && (m_running || m_over);
    tick    = m_running && !gs && (((m_edges + 1) % TICK_DIV) == 0);
    nh      = 0;
    for (int c = 0; c < 2; c++) begin
      idx   = (c == 0) ? int'(t1active_read[3:0]) : int'(t2active_read[3:0]);
      valid = (idx >= 4) && (idx <= 9);
      if (restart) begin
        m_timer[c] = 0;
        m_hit[c]   = 0;
      end else if (idx != m_prev[c]) begin
        m_prev[c]  = idx;
        m_hit[c]   = 0;
        m_timer[c] = valid ? m_reload : 0;
      end else if (m_running) begin
        if (valid && m_timer[c] > 0 && !m_hit[c] && rise[idx-4]) begin
          m_hit[c] = 1;
          nh++;
        end else if (tick && !m_hit[c] && m_timer[c] > 0) begin
          m_timer[c]--;
        end
      end
    end
`ifdef TARGET_SPEEDUP_EN
    if (gs) m_reload = TARGET_MS;
    else    m_reload = (m_reload - STEP_MS * nh < MIN_MS) ? MIN_MS : m_reload - STEP_MS * nh;
`endif
    if (gs) begin
      m_running = 1; m_over = 0; m_edges = 0; m_game = GAME_MS;
    end else if (m_running) begin
      m_edges++;
      m_game = GAME_MS - m_edges / TICK_DIV;
      if (m_game == 0) begin
        m_running = 0;
        m_over    = 1;
      end
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = button_in;
    e.bp = {26'b0, m_hist[1]};
    e.h1 = {31'b0, m_hit[0]};
    e.h2 = {31'b0, m_hit[1]};
    e.t1 = m_timer[0];
    e.t2 = m_timer[1];
    e.gt = m_game;
    e.go = {31'b0, m_over};
    sb.push_back(e);
    m_live = 1;
  endtask

  always @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) modelReset();
    else               modelStep();
  end

  // Monitor: every cycle the DUT presents a fresh register state to compare.
  always @(negedge clock) begin
    if (ctrl_reset_n && m_live) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty actual=0 entries expected=1 at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_bp", bp_write, mon_e.bp);
        checkOutput("sb_hit1", t1hit_write, mon_e.h1);
        checkOutput("sb_hit2", t2hit_write, mon_e.h2);
        checkOutput("sb_timer1", timer1_write, mon_e.t1);
        checkOutput("sb_timer2", timer2_write, mon_e.t2);
        checkOutput("sb_gametimer", gametimer_write, mon_e.gt);
        checkOutput("sb_game_over", {31'b0, game_over}, mon_e.go);
      end
    end
  end

  task automatic applyStimulus(input logic gs, input logic [5:0] b, input logic [3:0] i1, input logic [3:0] i2);
    game_start    = gs;
    button_in     = b;
    t1active_read = {28'b0, i1};
    t2active_read = {28'b0, i2};
    @(posedge clock);
    #1;
  endtask

  int         exp_reload [4];
  logic [5:0] rb;
  logic [3:0] r1, r2;
  int         bi;

  initial begin
`ifdef TARGET_SPEEDUP_EN
    exp_reload = '{10, 7, 4, 4};
`else
    exp_reload = '{10, 10, 10, 10};
`endif
    repeat (3) @(posedge clock);
    #1;
    checkResetValues("reset");
    ctrl_reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Full game: 50 ms at 4 cycles per ms
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 210; i++) begin
      applyStimulus(0, 6'($urandom_range(0, 63)), 0, 0);
      if (i == 199) begin
        checkOutput("game_199_timer", gametimer_write, 1);
        checkOutput("game_199_over", {31'b0, game_over}, 0);
      end
      if (i == 200 || i == 210) begin
        checkOutput("game_end_timer", gametimer_write, 0);
        checkOutput("game_end_over", {31'b0, game_over}, 1);
      end
    end

    // Target load and countdown to zero
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 5, 0);
    checkOutput("load_timer1", timer1_write, TARGET_MS);
    repeat (45) applyStimulus(0, 0, 5, 0);
    checkOutput("countdown_zero", timer1_write, 0);
    repeat (5) applyStimulus(0, 0, 5, 0);
    checkOutput("countdown_stays_zero", timer1_write, 0);

    // Hit on idx 6 via button 2, then index change clears it
    applyStimulus(0, 0, 6, 0);
    checkOutput("load6_timer1", timer1_write, TARGET_MS);
    repeat (4) applyStimulus(0, 6'b000100, 6, 0);
    checkOutput("hit6", {31'b0, t1hit_write[0]}, 1);
    repeat (8) applyStimulus(0, 0, 6, 0);
    checkOutput("hit6_sticky", t1hit_write, 1);
    applyStimulus(0, 0, 7, 0);
    checkOutput("idx7_hit_clear", t1hit_write, 0);
    checkOutput("idx7_reload", timer1_write, TARGET_MS);

    // Button edge coincides with index change to 8
    applyStimulus(0, 6'b010000, 7, 0);
    applyStimulus(0, 6'b010000, 7, 0);
    repeat (5) applyStimulus(0, 6'b010000, 8, 0);
    checkOutput("change_beats_hit", t1hit_write, 0);
    repeat (3) applyStimulus(0, 0, 8, 0);

    // Restart zeroes timers; a press with timer at zero is ignored
    applyStimulus(1, 0, 8, 0);
    checkOutput("restart_timer1", timer1_write, 0);
    repeat (4) applyStimulus(0, 6'b010000, 8, 0);
    checkOutput("zero_timer_no_hit", t1hit_write, 0);
    repeat (3) applyStimulus(0, 0, 8, 0);

    // Both channels on idx 4 hit together, then asynchronous reset mid-game
    applyStimulus(0, 0, 4, 4);
    checkOutput("dual_load1", timer1_write, TARGET_MS);
    checkOutput("dual_load2", timer2_write, TARGET_MS);
    repeat (4) applyStimulus(0, 6'b000001, 4, 4);
    checkOutput("dual_hit1", t1hit_write, 1);
    checkOutput("dual_hit2", t2hit_write, 1);
    ctrl_reset_n = 1'b0;
    #1;
    checkResetValues("midgame_reset");
    game_start = 0; button_in = '0; t1active_read = '0; t2active_read = '0;
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Sequential hits and the reload seen by each new target
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 4'(5 + k), 0);
      checkOutput($sformatf("reload_load%0d", k), timer1_write, exp_reload[k]);
      if (k < 3) begin
        repeat (4) applyStimulus(0, 6'(1 << (k + 1)), 4'(5 + k), 0);
        checkOutput($sformatf("reload_hit%0d", k), t1hit_write, 1);
      end
    end

    // Randomized soak against the model
    rb = '0; r1 = 4'd5; r2 = 4'd6;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bi     = $urandom_range(0, 5);
        rb[bi] = ~rb[bi];
      end
      if ($urandom_range(0, 24) == 0)
        r1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 9));
      if ($urandom_range(0, 24) == 0)
        r2 = ($urandom_range(0, 2) == 0) ? r1 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 399) == 0), rb, r1, r2);
    end
    applyStimulus(0, rb, r1, r2);
    applyStimulus(0, rb, r1, r2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
